// File: rtl/zmips_mem_arbiter_if.sv
// zmips_mem_arbiter_if: IF/MEM request-ack ports plus the shared memory bus.
// slave = arbiter side, master = pipeline stages and memory.
interface zmips_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        bus_err;
    logic        stall;
    logic        busy;

    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_rdata;
    logic        m_ready;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata, m_ready,
        output if_rdata, if_ack,
        output d_rdata, d_ack,
        output bus_err, stall, busy,
        output m_addr, m_wdata, m_rd, m_wr
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata, m_ready,
        input  if_rdata, if_ack,
        input  d_rdata, d_ack,
        input  bus_err, stall, busy,
        input  m_addr, m_wdata, m_rd, m_wr
    );
endinterface

// File: rtl/zmips_mem_arbiter.sv
// zmips_mem_arbiter: one memory access at a time for IF and MEM, with timeout.
// Define ZMIPS_MEMARB_RR_EN for round-robin ties; default is data-side first.
module zmips_mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    zmips_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t      state;
    logic        owner;
    logic        we;
    logic [7:0]  cnt;
    logic        grant_d;
    logic        timeout_hit;
    logic [31:0] acc_data;

    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
    // a timed-out load returns zero
    assign acc_data = bus.m_ready ? bus.m_rdata : 32'd0;

`ifdef ZMIPS_MEMARB_RR_EN
    logic last_grant;

    always_comb begin
        grant_d = bus.d_req;
        if (bus.if_req && bus.d_req)
            grant_d = ~last_grant;
    end
`else
    assign grant_d = bus.d_req;
`endif

    assign bus.busy  = (state != IDLE);
    assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

    // falling edge: same edge as the pipeline registers
    always_ff @(negedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            we           <= 1'b0;
            cnt          <= 8'd0;
            bus.m_addr   <= 32'd0;
            bus.m_wdata  <= 32'd0;
            bus.m_rd     <= 1'b0;
            bus.m_wr     <= 1'b0;
            bus.if_ack   <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.if_rdata <= 32'd0;
            bus.d_rdata  <= 32'd0;
            bus.bus_err  <= 1'b0;
`ifdef ZMIPS_MEMARB_RR_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            bus.if_ack  <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        owner <= grant_d;
                        cnt   <= 8'd0;
                        state <= ACC;
                        if (grant_d) begin
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                            we          <= bus.d_we;
                            bus.m_rd    <= ~bus.d_we;
                            bus.m_wr    <= bus.d_we;
                        end else begin
                            bus.m_addr  <= bus.if_addr;
                            bus.m_wdata <= 32'd0;
                            we          <= 1'b0;
                            bus.m_rd    <= 1'b1;
                            bus.m_wr    <= 1'b0;
                        end
`ifdef ZMIPS_MEMARB_RR_EN
                        last_grant <= grant_d;
`endif
                    end
                end
                ACC: begin
                    cnt <= cnt + 8'd1;
                    // m_ready beats a coincident timeout
                    if (bus.m_ready || timeout_hit) begin
                        state       <= RESP;
                        bus.m_rd    <= 1'b0;
                        bus.m_wr    <= 1'b0;
                        bus.if_ack  <= ~owner;
                        bus.d_ack   <= owner;
                        bus.bus_err <= ~bus.m_ready;
                        if (!we) begin
                            if (owner)
                                bus.d_rdata <= acc_data;
                            else
                                bus.if_rdata <= acc_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/zmips_mem_arbiter.md
# zmips_mem_arbiter

Two-port arbiter that shares one external single-ported memory bus between the zmips IF stage (instruction fetch) and the MEM stage (load/store). It accepts a request from each side and runs one bus access at a time, with a variable-wait handshake and a timeout. It returns the read data with a one-cycle acknowledge and drives a stall signal that the hazard detection unit uses to freeze the pipeline.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of access cycles without m_ready before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  core clock; all state updates on the falling edge, the same edge as the pipeline registers.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched word; valid while if_ack is high.
- if_ack  out  1  one-cycle completion pulse for a fetch.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid while d_ack is high.
- d_ack  out  1  one-cycle completion pulse for a data access.
- bus_err  out  1  high together with the ack of an access that timed out.
- stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack); combinational.
- busy  out  1  high in ACC and RESP states.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rd  out  1  memory read strobe.
- m_wr  out  1  memory write strobe.
- m_rdata  in  32  memory read data.
- m_ready  in  1  memory completion; sampled only in ACC.

## Operation
FSM with three states: IDLE, ACC, RESP. A one-bit register `owner` records which side holds the bus (I or D).

- **IDLE**
  - m_rd = 0 and m_wr = 0.
  - If any request is pending, select a winner per the Configuration section.
  - Latch into registers: address, wdata, we (forced to 0 for a fetch) and owner.
  - Clear the wait counter and go to ACC.
- **ACC**
  - Drive m_addr and m_wdata from the latched registers.
  - m_rd = ~we and m_wr = we.
  - Wait counter increments each cycle.
  - If m_ready is high: capture m_rdata into the owner's rdata register and go to RESP with err = 0.
  - Else if counter == TIMEOUT-1: load rdata with 0 and go to RESP with err = 1.
- **RESP**
  - m_rd = 0 and m_wr = 0.
  - The owner's ack is high for exactly one cycle; bus_err = err.
  - Requests are not sampled in RESP. Next state is IDLE.
- **Request protocol**
  - The requester drops or changes its request in the cycle after ack; a high req in IDLE is always a new request.
  - The requester holds address and data stable until ack.
- **Data outputs**
  - if_rdata and d_rdata hold their last value between acks.
  - The rdata of a store ack is undefined-stable (holds its last value).
- **Ignored inputs**
  - m_ready outside ACC is ignored.
  - Input changes during ACC are ignored because the transaction was latched in IDLE.

## Timing
- **Reset values:** state IDLE, m_rd = 0, m_wr = 0, m_addr = 0, m_wdata = 0, if_ack = 0, d_ack = 0, if_rdata = 0, d_rdata = 0, bus_err = 0, busy = 0, counter = 0, last_grant = D.
- **Zero-wait access:**
  - req is sampled at edge 0.
  - ACC occupies cycle 1, and m_ready is sampled at the end of cycle 1.
  - ack is high in cycle 2.
  - The next grant is decided at the end of cycle 3 (IDLE).
  - Throughput: one access per 3 cycles plus wait states.
- **N wait states:** ACC lasts N+1 cycles; ack follows in the next cycle.
- **Timeout:** ACC lasts exactly TIMEOUT cycles.
- **m_ready and timeout in the same cycle:** m_ready wins and err = 0.
- **Reset mid-access:** rst at any edge returns the FSM to IDLE, and the strobes are low in the next cycle. No ack is issued for the aborted access, and pending requests are re-arbitrated from IDLE once rst is low.

## Configuration
- **ZMIPS_MEMARB_RR_EN defined:** round-robin arbitration.
  - When both requests are pending in IDLE, the side not equal to last_grant wins.
  - last_grant updates on every grant.
  - After reset the instruction side wins the first tie.
- **ZMIPS_MEMARB_RR_EN undefined:** fixed priority, data side always wins a tie. The last_grant register is absent.
- In both modes a single pending request is granted immediately.

## Test plan
- **Zero-wait fetch:** if_req with if_addr = 0x00000100 and m_rdata = 0x12345678, m_ready tied high → m_rd = 1 with m_addr = 0x100 in cycle 1; if_ack = 1 with if_rdata = 0x12345678 in cycle 2; d_ack stays 0.
- **Store with 3 wait states:** d_req, d_we = 1, d_addr = 0x00002000, d_wdata = 0xCAFEF00D, m_ready high in the 4th ACC cycle → m_wr high for 4 cycles with those values; d_ack in the next cycle; bus_err = 0; m_rd never high.
- **Simultaneous requests, back-to-back:** 4 load/fetch pairs presented together.
  - Fixed priority: each pair grants D, then I.
  - ZMIPS_MEMARB_RR_EN: grants I, D, I, D, ... starting with I after reset.
- **Timeout:** TIMEOUT = 16, load with m_ready held low → m_rd high for exactly 16 cycles, then d_ack = 1, bus_err = 1, d_rdata = 0; the next access completes normally with bus_err = 0.
- **Reset mid-access:** rst in the 2nd ACC cycle of a load → m_rd = 0 in the next cycle; no d_ack; outputs at reset values; after rst falls, the held d_req completes normally.
- **Stall:** stall is high from the cycle req rises through the last ACC cycle, low in the ack cycle, and low while no request is pending.
